// File: rtl/mem_lsu_if.sv
// Data-memory bus between the load/store unit and the memory.
// The LSU drives the request side and the memory returns the ready/read side.
interface mem_lsu_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ready;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  dmem_ready, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output dmem_ready, dmem_rvalid, dmem_rdata
  );
endinterface

// File: rtl/mem_lsu.sv
// Load/store unit: one outstanding access, byte-lane store formatting,
// aligned and extended load results, misaligned accesses rejected in place.
module mem_lsu_lane #(
  parameter int LANE = 0
) (
  input  logic        is_b,
  input  logic        is_h,
  input  logic [1:0]  off,
  input  logic [31:0] rs2,
  output logic        be,
  output logic [7:0]  wbyte
);
  always_comb begin
    be    = 1'b1;
    wbyte = rs2[8*LANE +: 8];
    if (is_b) begin
      be    = (off == 2'(LANE));
      wbyte = rs2[7:0];
    end else if (is_h) begin
      be    = (off[1] == 1'(LANE / 2));
      wbyte = rs2[8*(LANE % 2) +: 8];
    end
  end
endmodule

module mem_lsu (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid_in,
  input  logic        MemRW_in,
  input  logic        memRead_in,
  input  logic [2:0]  funct3_in,
  input  logic [31:0] ALU_res_in,
  input  logic [31:0] rs2_in,
  output logic        stall_out,
  output logic [31:0] ld_data_out,
  output logic        ld_valid_out,
  output logic        misalign_out,
  mem_lsu_if.master   dmem
);
  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 8;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

  typedef struct packed {
    logic       we;
    logic [2:0] f3;
    logic [1:0] off;
  } req_t;

  state_e state, state_nxt;
  req_t   req_q;

  logic                              mem_op, is_b, is_h, misaligned, accept;
  logic                              stall, req;
  logic [NUM_LANES-1:0]              be_d, be_q;
  logic [NUM_LANES-1:0][VEC_W-1:0]   wdata_d, wdata_q;
  logic [31:0]                       addr_q, ld_ext, rshift;

  // funct3[1:0] selects width; 011/110/111 fall through to word.
  assign is_b       = (funct3_in[1:0] == 2'b00);
  assign is_h       = (funct3_in[1:0] == 2'b01);
  assign mem_op     = ex_valid_in & (MemRW_in | memRead_in);
  assign misaligned = (is_h & ALU_res_in[0]) | (~is_b & ~is_h & (|ALU_res_in[1:0]));
  assign accept     = (state == IDLE) & mem_op & ~misaligned;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    mem_lsu_lane #(.LANE(i)) u_lane (
      .is_b  (is_b),
      .is_h  (is_h),
      .off   (ALU_res_in[1:0]),
      .rs2   (rs2_in),
      .be    (be_d[i]),
      .wbyte (wdata_d[i])
    );
  end

  always_comb begin
    rshift = dmem.dmem_rdata >> {req_q.off, 3'b000};
    case (req_q.f3[1:0])
      2'b00:   ld_ext = {{24{~req_q.f3[2] & rshift[7]}}, rshift[7:0]};
      2'b01: begin
        rshift = dmem.dmem_rdata >> {req_q.off[1], 4'b0000};
        ld_ext = {{16{~req_q.f3[2] & rshift[15]}}, rshift[15:0]};
      end
      default: ld_ext = dmem.dmem_rdata;
    endcase
  end

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    req       = 1'b0;
    case (state)
      IDLE: if (accept) begin
        stall     = 1'b1;
        state_nxt = REQ;
      end
      REQ: begin
        stall = 1'b1;
        req   = 1'b1;
        if (dmem.dmem_ready) state_nxt = req_q.we ? DONE : WAIT;
      end
      WAIT: begin
        stall = 1'b1;
        if (dmem.dmem_rvalid) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      req_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      ld_data_out  <= '0;
      ld_valid_out <= 1'b0;
      misalign_out <= 1'b0;
    end else begin
      state        <= state_nxt;
      ld_valid_out <= (state == WAIT) & dmem.dmem_rvalid;
      misalign_out <= (state == IDLE) & mem_op & misaligned;
      if (accept) begin
        req_q   <= '{we: MemRW_in, f3: funct3_in, off: ALU_res_in[1:0]};
        addr_q  <= {ALU_res_in[31:2], 2'b00};
        wdata_q <= wdata_d;
        be_q    <= be_d;
      end
      if ((state == WAIT) && dmem.dmem_rvalid) ld_data_out <= ld_ext;
    end
  end

  assign stall_out       = stall & ~reset;
  assign dmem.dmem_req   = req;
  assign dmem.dmem_we    = req_q.we;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_wdata = wdata_q;
  assign dmem.dmem_be    = be_q;
endmodule

// File: tb/tb_mem_lsu.sv
// Directed plus random load/store sequences against an arithmetic model of
// byte enables, lane replication, load extension and stall length.
module tb_mem_lsu;
  logic        clk = 1'b0;
  logic        reset, ex_valid_in, MemRW_in, memRead_in;
  logic [2:0]  funct3_in;
  logic [31:0] ALU_res_in, rs2_in;
  logic        stall_out, ld_valid_out, misalign_out;
  logic [31:0] ld_data_out;
  logic [31:0] last_ld = 32'h0;
  int          total = 0, bad = 0;

  mem_lsu_if bus();

  mem_lsu dut (
    .clk          (clk),
    .reset        (reset),
    .ex_valid_in  (ex_valid_in),
    .MemRW_in     (MemRW_in),
    .memRead_in   (memRead_in),
    .funct3_in    (funct3_in),
    .ALU_res_in   (ALU_res_in),
    .rs2_in       (rs2_in),
    .stall_out    (stall_out),
    .ld_data_out  (ld_data_out),
    .ld_valid_out (ld_valid_out),
    .misalign_out (misalign_out),
    .dmem         (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // 0 = byte, 1 = half, 2 = word
  function automatic int wsz(input logic [2:0] f);
    if (f[1:0] == 2'b00) return 0;
    if (f[1:0] == 2'b01) return 1;
    return 2;
  endfunction

  function automatic bit misal(input logic [2:0] f, input logic [31:0] a);
    if (wsz(f) == 1) return (a % 2) != 0;
    if (wsz(f) == 2) return (a % 4) != 0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] exp_be(input logic [2:0] f, input logic [31:0] a);
    int off = int'(a % 4);
    if (wsz(f) == 0) return 32'(1 << off);
    if (wsz(f) == 1) return 32'(3 << (2 * (off / 2)));
    return 32'hF;
  endfunction

  function automatic logic [31:0] exp_wd(input logic [2:0] f, input logic [31:0] d);
    if (wsz(f) == 0) return (d & 32'hFF) * 32'h01010101;
    if (wsz(f) == 1) return (d & 32'hFFFF) * 32'h00010001;
    return d;
  endfunction

  function automatic logic [31:0] exp_ld(input logic [2:0] f, input logic [31:0] a,
                                         input logic [31:0] r);
    int off = int'(a % 4);
    logic [31:0] v;
    if (wsz(f) == 0) begin
      v = (r >> (8 * off)) & 32'hFF;
      if (!f[2] && v >= 32'h80) v = v | 32'hFFFFFF00;
    end else if (wsz(f) == 1) begin
      v = (r >> (16 * (off / 2))) & 32'hFFFF;
      if (!f[2] && v >= 32'h8000) v = v | 32'hFFFF0000;
    end else begin
      v = r;
    end
    return v;
  endfunction

  task automatic run_op(input bit st, input bit both, input logic [2:0] f,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] rdata, input int rdly, input int vdly);
    int stalls = 0;
    bit mis = misal(f, a);
    ex_valid_in = 1'b1; MemRW_in = st; memRead_in = !st || both;
    funct3_in = f; ALU_res_in = a; rs2_in = d;
    #1;
    chk("idle_stall", 32'(stall_out), 32'(!mis));
    stalls += int'(stall_out);
    cyc();
    ex_valid_in = 1'b0; MemRW_in = 1'b0; memRead_in = 1'b0;
    ALU_res_in = $urandom; rs2_in = $urandom; funct3_in = 3'($urandom);
    if (mis) begin
      chk("mis_pulse", 32'(misalign_out), 32'h1);
      chk("mis_req", 32'(bus.dmem_req), 32'h0);
      chk("mis_stall", 32'(stall_out), 32'h0);
      cyc();
      chk("mis_clear", 32'(misalign_out), 32'h0);
      chk("mis_req2", 32'(bus.dmem_req), 32'h0);
      return;
    end
    chk("no_mis", 32'(misalign_out), 32'h0);
    for (int k = 0; k <= rdly; k++) begin
      bus.dmem_ready = (k == rdly);
      bus.dmem_rvalid = !st;
      bus.dmem_rdata = $urandom;
      #1;
      chk("req_req", 32'(bus.dmem_req), 32'h1);
      chk("req_stall", 32'(stall_out), 32'h1);
      chk("req_addr", bus.dmem_addr, a & 32'hFFFFFFFC);
      chk("req_be", 32'(bus.dmem_be), st ? exp_be(f, a) : 32'(bus.dmem_be) | exp_be(f, a));
      if (st) chk("req_wdata", bus.dmem_wdata, exp_wd(f, d));
      chk("req_we", 32'(bus.dmem_we), 32'(st));
      stalls++;
      cyc();
    end
    bus.dmem_ready = 1'b0; bus.dmem_rvalid = 1'b0;
    if (!st) begin
      for (int k = 0; k <= vdly; k++) begin
        bus.dmem_rvalid = (k == vdly);
        bus.dmem_rdata = (k == vdly) ? rdata : $urandom;
        #1;
        chk("wait_stall", 32'(stall_out), 32'h1);
        chk("wait_req", 32'(bus.dmem_req), 32'h0);
        chk("wait_ldv", 32'(ld_valid_out), 32'h0);
        stalls++;
        cyc();
      end
      last_ld = exp_ld(f, a, rdata);
    end
    // DONE: a new op and a stray rvalid here must both be ignored
    ex_valid_in = 1'b1; MemRW_in = 1'b1; funct3_in = 3'b010; ALU_res_in = 32'h0;
    bus.dmem_rvalid = 1'b1; bus.dmem_rdata = $urandom;
    #1;
    chk("done_stall", 32'(stall_out), 32'h0);
    chk("done_ldv", 32'(ld_valid_out), 32'(!st));
    chk("done_ldata", ld_data_out, last_ld);
    chk("stall_cnt", 32'(stalls), st ? 32'(2 + rdly) : 32'(3 + rdly + vdly));
    cyc();
    ex_valid_in = 1'b0; MemRW_in = 1'b0; bus.dmem_rvalid = 1'b0;
    #1;
    chk("post_req", 32'(bus.dmem_req), 32'h0);
    chk("post_stall", 32'(stall_out), 32'h0);
    chk("post_ldv", 32'(ld_valid_out), 32'h0);
    chk("hold_ldata", ld_data_out, last_ld);
    cyc();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ldata"}, ld_data_out, 32'h0);
    chk({tag, "_ldv"}, 32'(ld_valid_out), 32'h0);
    chk({tag, "_mis"}, 32'(misalign_out), 32'h0);
    chk({tag, "_req"}, 32'(bus.dmem_req), 32'h0);
    chk({tag, "_we"}, 32'(bus.dmem_we), 32'h0);
    chk({tag, "_addr"}, bus.dmem_addr, 32'h0);
    chk({tag, "_wdata"}, bus.dmem_wdata, 32'h0);
    chk({tag, "_be"}, 32'(bus.dmem_be), 32'h0);
  endtask

  initial begin
    reset = 1'b1; ex_valid_in = 1'b1; MemRW_in = 1'b1; memRead_in = 1'b0;
    funct3_in = 3'b010; ALU_res_in = 32'h100; rs2_in = 32'h0;
    bus.dmem_ready = 1'b0; bus.dmem_rvalid = 1'b0; bus.dmem_rdata = 32'h0;
    #1;
    chk("rst_stall", 32'(stall_out), 32'h0);
    cyc(); cyc();
    chk_zero("rst");
    reset = 1'b0; ex_valid_in = 1'b0; MemRW_in = 1'b0;

    run_op(1, 0, 3'b000, 32'h1003, 32'h000000A5, 32'h0, 0, 0);
    run_op(0, 0, 3'b000, 32'h2001, 32'h0, 32'h0000F000, 0, 2);
    run_op(0, 0, 3'b100, 32'h2001, 32'h0, 32'h0000F000, 0, 2);
    run_op(0, 0, 3'b010, 32'h3002, 32'h0, 32'h0, 0, 0);
    run_op(1, 0, 3'b010, 32'h5004, 32'hDEADBEEF, 32'h0, 4, 0);
    run_op(1, 1, 3'b001, 32'h6006, 32'h1234ABCD, 32'h0, 1, 0);
    run_op(0, 0, 3'b101, 32'h7002, 32'h0, 32'h9876FEDC, 2, 1);
    run_op(0, 0, 3'b011, 32'h7001, 32'h0, 32'h0, 0, 0);
    run_op(1, 0, 3'b001, 32'h7003, 32'h0, 32'h0, 0, 0);
    run_op(0, 0, 3'b110, 32'h8000, 32'h0, 32'hCAFEF00D, 0, 0);

    // abort a halfword load in WAIT; the late data must not complete it
    ex_valid_in = 1'b1; MemRW_in = 1'b0; memRead_in = 1'b1;
    funct3_in = 3'b001; ALU_res_in = 32'h4002;
    cyc();
    ex_valid_in = 1'b0; memRead_in = 1'b0; bus.dmem_ready = 1'b1;
    #1;
    chk("abort_req", 32'(bus.dmem_req), 32'h1);
    cyc();
    bus.dmem_ready = 1'b0;
    #1;
    chk("abort_wait", 32'(stall_out), 32'h1);
    reset = 1'b1;
    #1;
    chk("abort_rst_stall", 32'(stall_out), 32'h0);
    cyc();
    reset = 1'b0; bus.dmem_rvalid = 1'b1; bus.dmem_rdata = 32'h80000000;
    #1;
    chk_zero("abort");
    chk("abort_stall", 32'(stall_out), 32'h0);
    cyc();
    bus.dmem_rvalid = 1'b0;
    #1;
    chk("late_ldv", 32'(ld_valid_out), 32'h0);
    chk("late_ldata", ld_data_out, 32'h0);
    last_ld = 32'h0;
    run_op(0, 0, 3'b001, 32'h4002, 32'h0, 32'h80000000, 0, 0);
    chk("lh_after_abort", ld_data_out, 32'hFFFF8000);

    for (int i = 0; i < 40; i++) begin
      bit st = 1'($urandom);
      run_op(st, st & 1'($urandom), 3'($urandom), $urandom, $urandom, $urandom,
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_lsu.md
MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 Clocking SHALL be: one clock; reset is synchronous and active-high.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 reset  in  1  synchronous, active-high; clears all state at the next clk edge.
REQ-004 ex_valid_in  in  1  EX/MEM slot holds a valid instruction.
REQ-005 MemRW_in  in  1  1 = store.
REQ-006 memRead_in  in  1  1 = load.
REQ-007 funct3_in  in  3  access width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 ALU_res_in  in  32  byte address.
REQ-009 rs2_in  in  32  store data.
REQ-010 stall_out  out  1  holds the upstream pipeline.
REQ-011 ld_data_out  out  32  aligned, extended load result.
REQ-012 ld_valid_out  out  1  one-cycle pulse; ld_data_out is valid.
REQ-013 misalign_out  out  1  one-cycle pulse; misaligned access was rejected.
REQ-014 dmem_req  out  1  memory request.
REQ-015 dmem_we  out  1  1 = write request.
REQ-016 dmem_addr  out  32  word address, with bits [1:0] = 00.
REQ-017 dmem_wdata  out  32  lane-replicated store data.
REQ-018 dmem_be  out  4  byte enables.
REQ-019 dmem_ready  in  1  memory accepts the request this cycle.
REQ-020 dmem_rvalid  in  1  read data is valid this cycle.
REQ-021 dmem_rdata  in  32  read data word.

Function
REQ-022 The FSM SHALL have four states: IDLE, REQ, WAIT, DONE.
REQ-023 A memory op SHALL be defined as ex_valid_in & (MemRW_in | memRead_in); when both MemRW_in and memRead_in are set, the op SHALL be treated as a store.
REQ-024 Misalignment SHALL be: H/HU with addr[0]=1, or W with addr[1:0]!=00; funct3 values 011, 110 and 111 SHALL be treated as W.
REQ-025 IDLE, misaligned op: misalign_out SHALL pulse for exactly one cycle; no dmem request is issued; stall_out stays 0; state stays IDLE.
REQ-026 IDLE, aligned op: stall_out SHALL be asserted combinationally in the same cycle; addr, be, wdata, we and funct3 are registered; the FSM enters REQ at the next edge.
REQ-027 REQ: dmem_req=1 and stall_out=1; all dmem outputs SHALL stay stable until dmem_ready=1.
  - dmem_ready=1 on a store: go to DONE.
  - dmem_ready=1 on a load: go to WAIT.
REQ-028 WAIT: stall_out=1, dmem_req=0; on dmem_rvalid=1, extracted data SHALL be captured into ld_data_out and the FSM goes to DONE.
REQ-029 dmem_rvalid in the same cycle as dmem_ready SHALL NOT be accepted; read data SHALL be accepted in WAIT only.
REQ-030 DONE: stall_out=0; ld_valid_out=1 for loads only; the FSM returns to IDLE; ex_valid_in SHALL be ignored in DONE.
REQ-031 Byte enables SHALL be:
  - B: 0001<<addr[1:0].
  - H: 0011<<(2*addr[1]).
  - W: 1111.
REQ-032 Write data SHALL be:
  - SB: {4{rs2[7:0]}}.
  - SH: {2{rs2[15:0]}}.
  - SW: rs2.
REQ-033 Load extraction SHALL be:
  - LB/LBU: byte at lane addr[1:0], sign-extended or zero-extended.
  - LH/LHU: halfword at lane addr[1], sign-extended or zero-extended.
  - LW: the full word.
REQ-034 ld_data_out SHALL hold its value until the next load completes.
REQ-035 Latency: a store with dmem_ready=1 on the first REQ cycle SHALL have stall_out high for exactly 2 cycles (IDLE, REQ).
REQ-036 Load latency SHALL be 2 + (REQ wait cycles) + (WAIT cycles) with stall_out high.
REQ-037 dmem_rvalid outside WAIT SHALL be ignored.

Reset
REQ-038 reset=1 SHALL, at the next clk edge, force: state=IDLE; ld_data_out=0; ld_valid_out=0; misalign_out=0; dmem_req=0; dmem_we=0; dmem_addr=0; dmem_wdata=0; dmem_be=0; all internal registers=0.
REQ-039 stall_out SHALL be 0 while reset=1.
REQ-040 Reset asserted in REQ or WAIT SHALL abort the access; a late dmem_rvalid after reset SHALL produce no ld_valid_out.

Verification
REQ-041 SB, addr=0x1003, rs2=0x000000A5, dmem_ready=1 immediately -> dmem_be=1000, dmem_wdata=0xA5A5A5A5, dmem_addr=0x1000, dmem_we=1, stall_out high 2 cycles.
REQ-042 LB, addr=0x2001, rdata=0x0000F000, rvalid 3 cycles after ready -> ld_data_out=0xFFFFFFF0, ld_valid_out pulses once in DONE; repeat as LBU -> 0x000000F0.
REQ-043 LW, addr=0x3002 -> misalign_out pulses 1 cycle, dmem_req never asserted, stall_out=0.
REQ-044 SW with dmem_ready held 0 for 4 cycles -> dmem_addr, dmem_wdata and dmem_be stable throughout REQ; stall_out high 6 cycles total.
REQ-045 LH, addr=0x4002, reset asserted during WAIT, then rvalid=1 with rdata=0x80000000 -> all outputs 0, no ld_valid_out; a subsequent LH completes normally with ld_data_out=0xFFFF8000.
